// File: rtl/run_ctrl.sv
// run_ctrl: processor run controller with watchdog, cycle-count capture and serial report
// Ports: clk/rst (sync, active-high); start requests a run; halt/cc come from the core;
// en enables the core; busy/done/timeout give status; cc_cap holds the captured count;
// tx_bit/tx_valid/tx_ready form the LSB-first 1-bit serial link.
// Optional macro RUN_CTRL_PARITY_EN appends an even-parity bit to each report.
module run_ctrl #(
  parameter int TIMEOUT = 200,
  parameter int CC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt,
  input  logic [CC_W-1:0] cc,
  output logic            en,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [CC_W-1:0] cc_cap,
  output logic            tx_bit,
  output logic            tx_valid,
  input  logic            tx_ready
);
`ifdef RUN_CTRL_PARITY_EN
  localparam int NB = CC_W + 1;
`else
  localparam int NB = CC_W;
`endif
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam int IW = $clog2(NB);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);
  typedef enum logic [1:0] {IDLE, RUN, REPORT, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d, idx_nx;
  logic en_q, en_d, busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic tx_bit_q, tx_bit_d, tx_valid_q, tx_valid_d, bit_nx;
  logic [CC_W-1:0] cc_cap_q, cc_cap_d, sh;
  assign idx_nx = idx_q + IW'(1);
  assign sh = cc_cap_q >> idx_nx;
`ifdef RUN_CTRL_PARITY_EN
  assign bit_nx = (idx_nx == IW'(CC_W)) ? ^cc_cap_q : sh[0];
`else
  assign bit_nx = sh[0];
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    en_d = en_q;
    busy_d = busy_q;
    done_d = done_q;
    timeout_d = timeout_q;
    cc_cap_d = cc_cap_q;
    tx_bit_d = tx_bit_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = RUN;
        cnt_d = '0;
        en_d = 1'b1;
        busy_d = 1'b1;
        done_d = 1'b0;
        timeout_d = 1'b0;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        // halt has priority over the watchdog when both fire together
        if (halt || cnt_q == CNT_LAST) begin
          state_d = REPORT;
          en_d = 1'b0;
          cc_cap_d = cc;
          timeout_d = !halt;
          idx_d = '0;
          tx_valid_d = 1'b1;
          tx_bit_d = cc[0];
        end
      end
      REPORT: if (tx_ready) begin
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          idx_d = '0;
          tx_valid_d = 1'b0;
          tx_bit_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          idx_d = idx_nx;
          tx_bit_d = bit_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      en_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
      cc_cap_q <= '0;
      tx_bit_q <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      en_q <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
      cc_cap_q <= cc_cap_d;
      tx_bit_q <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
    end
  end
  assign en = en_q;
  assign busy = busy_q;
  assign done = done_q;
  assign timeout = timeout_q;
  assign cc_cap = cc_cap_q;
  assign tx_bit = tx_bit_q;
  assign tx_valid = tx_valid_q;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl
module tb_run_ctrl;
`ifdef RUN_CTRL_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif
  logic clk = 0, rst = 0, start = 0, halt = 0, tx_ready = 0;
  logic [15:0] cc = 0;
  logic en, busy, done, timeout, tx_bit, tx_valid;
  logic [15:0] cc_cap;
  int total = 0, bad = 0;
  run_ctrl #(.TIMEOUT(200), .CC_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .cc(cc), .en(en), .busy(busy),
    .done(done), .timeout(timeout), .cc_cap(cc_cap), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [16:0] expv(input logic [15:0] v);
`ifdef RUN_CTRL_PARITY_EN
    return {^v, v};
`else
    return {1'b0, v};
`endif
  endfunction
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic drain(output logic [16:0] rx);
    rx = '0;
    tx_ready = 1;
    for (int i = 0; i < NB; i++) begin
      rx[i] = tx_bit;
      tick();
    end
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    total++; if ({en, busy, done, timeout, tx_bit, tx_valid} !== 6'b0) begin bad++; $display("FAIL rst_flags got=%b want=000000", {en, busy, done, timeout, tx_bit, tx_valid}); end
    total++; if (cc_cap !== 16'h0) begin bad++; $display("FAIL rst_cc_cap got=%h want=0000", cc_cap); end
    rst = 0;
    repeat (3) tick();
    total++; if ({en, busy, done} !== 3'b0) begin bad++; $display("FAIL idle_hold got=%b want=000", {en, busy, done}); end
  endtask
  task automatic test_halt();
    logic [16:0] rx;
    cc = 16'h0009;
    pulse_start();
    total++; if ({en, busy} !== 2'b11) begin bad++; $display("FAIL run_entry got=%b want=11", {en, busy}); end
    repeat (9) tick();
    total++; if (en !== 1'b1) begin bad++; $display("FAIL run_cycle10_en got=%b want=1", en); end
    halt = 1;
    tx_ready = 1;
    tick();
    halt = 0;
    cc = 16'hFFFF;
    total++; if ({en, timeout, tx_valid, busy} !== 4'b0011) begin bad++; $display("FAIL halt_stop got=%b want=0011", {en, timeout, tx_valid, busy}); end
    total++; if (cc_cap !== 16'h0009) begin bad++; $display("FAIL halt_cap got=%h want=0009", cc_cap); end
    rx = '0;
    for (int i = 0; i < NB; i++) begin
      total++; if ({tx_valid, done} !== 2'b10) begin bad++; $display("FAIL halt_tx_%0d got=%b want=10", i, {tx_valid, done}); end
      rx[i] = tx_bit;
      tick();
    end
    total++; if (rx !== expv(16'h0009)) begin bad++; $display("FAIL halt_stream got=%h want=%h", rx, expv(16'h0009)); end
    total++; if ({done, busy, tx_valid, timeout} !== 4'b1000) begin bad++; $display("FAIL halt_done got=%b want=1000", {done, busy, tx_valid, timeout}); end
  endtask
  task automatic test_watchdog();
    logic [16:0] rx;
    int n;
    cc = 16'h00C7;
    pulse_start();
    total++; if ({done, en} !== 2'b01) begin bad++; $display("FAIL wd_restart got=%b want=01", {done, en}); end
    n = 0;
    while (en === 1'b1 && n < 300) begin n++; tick(); end
    total++; if (n !== 200) begin bad++; $display("FAIL wd_en_len got=%0d want=200", n); end
    total++; if ({timeout, tx_valid} !== 2'b11) begin bad++; $display("FAIL wd_flag got=%b want=11", {timeout, tx_valid}); end
    total++; if (cc_cap !== 16'h00C7) begin bad++; $display("FAIL wd_cap got=%h want=00c7", cc_cap); end
    drain(rx);
    total++; if (rx !== expv(16'h00C7)) begin bad++; $display("FAIL wd_stream got=%h want=%h", rx, expv(16'h00C7)); end
    total++; if ({done, timeout} !== 2'b11) begin bad++; $display("FAIL wd_done got=%b want=11", {done, timeout}); end
  endtask
  task automatic test_simul();
    logic [16:0] rx;
    cc = 16'h1234;
    pulse_start();
    total++; if ({done, timeout, en} !== 3'b001) begin bad++; $display("FAIL sim_clear got=%b want=001", {done, timeout, en}); end
    repeat (199) tick();
    total++; if (en !== 1'b1) begin bad++; $display("FAIL sim_en200 got=%b want=1", en); end
    halt = 1;
    tick();
    halt = 0;
    total++; if ({en, timeout, tx_valid} !== 3'b001) begin bad++; $display("FAIL sim_stop got=%b want=001", {en, timeout, tx_valid}); end
    total++; if (cc_cap !== 16'h1234) begin bad++; $display("FAIL sim_cap got=%h want=1234", cc_cap); end
    drain(rx);
    total++; if (rx !== expv(16'h1234)) begin bad++; $display("FAIL sim_stream got=%h want=%h", rx, expv(16'h1234)); end
  endtask
  task automatic test_backpressure();
    logic [16:0] rx;
    logic prev_bit, prev_stall;
    int k;
    cc = 16'hA5A5;
    tx_ready = 0;
    pulse_start();
    halt = 1;
    tick();
    halt = 0;
    rx = '0;
    k = 0;
    prev_bit = 0;
    prev_stall = 0;
    for (int c = 0; c < 100 && done !== 1'b1; c++) begin
      if (prev_stall) begin
        total++; if (tx_bit !== prev_bit) begin bad++; $display("FAIL bp_hold_%0d got=%b want=%b", c, tx_bit, prev_bit); end
      end
      tx_ready = c[0];
      if (tx_valid && tx_ready && k < 17) begin rx[k] = tx_bit; k++; end
      prev_bit = tx_bit;
      prev_stall = tx_valid && !tx_ready;
      tick();
    end
    total++; if (k !== NB) begin bad++; $display("FAIL bp_count got=%0d want=%0d", k, NB); end
    total++; if (rx !== expv(16'hA5A5)) begin bad++; $display("FAIL bp_stream got=%h want=%h", rx, expv(16'hA5A5)); end
    total++; if ({done, tx_valid} !== 2'b10) begin bad++; $display("FAIL bp_done got=%b want=10", {done, tx_valid}); end
  endtask
  task automatic test_start_ignored();
    logic [16:0] rx;
    int n;
    cc = 16'h0042;
    pulse_start();
    n = 0;
    while (en === 1'b1 && n < 300) begin
      start = (n >= 2 && n < 6);
      n++;
      tick();
    end
    start = 0;
    total++; if (n !== 200) begin bad++; $display("FAIL ign_en_len got=%0d want=200", n); end
    total++; if ({timeout, cc_cap} !== {1'b1, 16'h0042}) begin bad++; $display("FAIL ign_cap got=%b/%h want=1/0042", timeout, cc_cap); end
    drain(rx);
  endtask
  task automatic test_reset_mid();
    pulse_start();
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    total++; if ({en, busy, done, timeout} !== 4'b0) begin bad++; $display("FAIL rst_run got=%b want=0000", {en, busy, done, timeout}); end
    cc = 16'hFFFF;
    pulse_start();
    halt = 1;
    tx_ready = 0;
    tick();
    halt = 0;
    tick();
    total++; if ({tx_valid, cc_cap} !== {1'b1, 16'hFFFF}) begin bad++; $display("FAIL rst_pre got=%b/%h want=1/ffff", tx_valid, cc_cap); end
    rst = 1;
    tick();
    rst = 0;
    total++; if ({tx_valid, tx_bit, busy, done} !== 4'b0) begin bad++; $display("FAIL rst_rep got=%b want=0000", {tx_valid, tx_bit, busy, done}); end
    total++; if (cc_cap !== 16'h0) begin bad++; $display("FAIL rst_rep_cap got=%h want=0000", cc_cap); end
    tick();
    total++; if (en !== 1'b0) begin bad++; $display("FAIL rst_idle_en got=%b want=0", en); end
  endtask
  initial begin
    test_reset();
    test_halt();
    test_watchdog();
    test_simul();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
